// File: rtl/serial_sum_decoder_pkg.sv
// Shared types and width helpers for the bit-serial sum decoder.
package serial_sum_decoder_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_e;

    // Sum operand width: one carry bit above the addend width.
    function automatic int unsigned sum_width(input int unsigned width);
        return width + 1;
    endfunction

    // Counter must reach WIDTH (the last processed bit index).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_bit (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Borrow when x is 0 and anything is taken, or when both y and bin are taken.
    always_comb begin
        d_o    = x_i ^ y_i ^ bin_i;
        bout_o = (~x_i & (y_i | bin_i)) | (y_i & bin_i);
    end

endmodule

// File: rtl/serial_sum_decoder.sv
// Recovers addend a from sum = a + b + cin, one bit per clock, LSB first.
module serial_sum_decoder
    import serial_sum_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] addend_i,
    input  logic             cin_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_o,
    output logic             err_o
);

    localparam int unsigned SUM_W = sum_width(WIDTH);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

    state_e           state_q;
    logic [SUM_W-1:0] sum_sr_q;
    logic [SUM_W-1:0] b_sr_q;
    logic [SUM_W-1:0] res_q;
    logic [SUM_W-1:0] res_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             diff_bit;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             err_q;

    // The cell is shared across all bit positions; the shift registers feed it.
    full_subtractor_bit u_cell (
        .x_i   (sum_sr_q[0]),
        .y_i   (b_sr_q[0]),
        .bin_i (borrow_q),
        .d_o   (diff_bit),
        .bout_o(borrow_d)
    );

    // Result register after this cycle's bit enters at the MSB.
    always_comb begin
        res_d = {diff_bit, res_q[SUM_W-1:1]};
    end

    // FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sum_sr_q <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_sr_q <= sum_i;
                        b_sr_q   <= {1'b0, addend_i};
                        borrow_q <= cin_i;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr_q <= sum_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    borrow_q <= borrow_d;
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        // A leftover borrow or a set top bit means a does not fit in WIDTH bits.
                        diff_q  <= res_d[WIDTH-1:0];
                        err_q   <= borrow_d | res_d[WIDTH];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff_o = diff_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_serial_sum_decoder.sv
// Self-checking bench for serial_sum_decoder (WIDTH=3) against an arithmetic model.
module tb_serial_sum_decoder;

    localparam int unsigned W = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W:0]   sum_i;
    logic [W-1:0] addend_i;
    logic         cin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] diff_o;
    logic         err_o;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sum_decoder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sum_i   (sum_i),
        .addend_i(addend_i),
        .cin_i   (cin_i),
        .busy    (busy),
        .done    (done),
        .diff_o  (diff_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction, error when a does not fit in W bits.
    function automatic logic [W-1:0] model_diff(input int s, input int b, input int c);
        int t;
        t = s - b - c;
        return W'(t & ((1 << W) - 1));
    endfunction

    function automatic logic model_err(input int s, input int b, input int c);
        int t;
        t = s - b - c;
        return (t < 0) || (t >= (1 << W));
    endfunction

    // Drives one start pulse from a negedge and waits (bounded) for done.
    // lat counts posedges after the accepting edge until done is seen.
    task automatic do_op(input int s, input int b, input int c, output int lat,
                         output int busy_cyc, output logic [W-1:0] d, output logic e,
                         output bit stable);
        logic [W-1:0] pre_d;
        logic         pre_e;
        pre_d    = diff_o;
        pre_e    = err_o;
        stable   = 1'b1;
        lat      = -1;
        busy_cyc = 0;
        d        = 'x;
        e        = 1'bx;
        sum_i    = (W+1)'(s);
        addend_i = W'(b);
        cin_i    = c[0];
        start    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                lat = k - 1;
                d   = diff_o;
                e   = err_o;
                break;
            end
            if (diff_o !== pre_d || err_o !== pre_e) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        sum_i    = '0;
        addend_i = '0;
        cin_i    = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, diff_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%0d err=%b, expected all 0",
                     busy, done, diff_o, err_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [W-1:0] d;
        logic e;
        bit st;
        do_op(10, 3, 1, lat, bc, d, e, st);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        n_checks++;
        if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
        n_checks++;
        if (d !== 3'd6 || e !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got diff=%0d err=%b expected diff=6 err=0", d, e);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        do_op(15, 7, 1, lat, bc, d, e, st);
        n_checks++;
        if (d !== 3'd7 || e !== 1'b0 || !st) begin
            n_fail++; $display("FAIL max_operands: got diff=%0d err=%b stable=%0d expected diff=7 err=0 stable=1",
                               d, e, st);
        end
        do_op(0, 0, 0, lat, bc, d, e, st);
        n_checks++;
        if (d !== 3'd0 || e !== 1'b0 || !st) begin
            n_fail++; $display("FAIL zero_operands: got diff=%0d err=%b stable=%0d expected diff=0 err=0 stable=1",
                               d, e, st);
        end
    endtask

    task automatic test_error();
        int lat, bc;
        logic [W-1:0] d;
        logic e;
        bit st;
        do_op(2, 5, 0, lat, bc, d, e, st);
        n_checks++;
        if (d !== 3'd5 || e !== 1'b1) begin
            n_fail++; $display("FAIL negative_diff: got diff=%0d err=%b expected diff=5 err=1", d, e);
        end
        do_op(8, 0, 0, lat, bc, d, e, st);
        n_checks++;
        if (d !== 3'd0 || e !== 1'b1) begin
            n_fail++; $display("FAIL overflow_diff: got diff=%0d err=%b expected diff=0 err=1", d, e);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int lat = -1;
        logic [W-1:0] d = '0;
        logic e = 1'b0;
        sum_i    = 4'd13;
        addend_i = 3'd6;
        cin_i    = 1'b1;
        start    = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                start    = 1'b1;
                sum_i    = 4'd0;
                addend_i = 3'd7;
                cin_i    = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = k - 1; d = diff_o; e = err_o; end
            end
        end
        n_checks++;
        if (ndone !== 1 || lat !== 4) begin
            n_fail++; $display("FAIL ignore_start_timing: got dones=%0d lat=%0d expected dones=1 lat=4",
                               ndone, lat);
        end
        n_checks++;
        if (d !== 3'd6 || e !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start_result: got diff=%0d err=%b expected diff=6 err=0", d, e);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] d;
        logic e;
        bit st;
        do_op(12, 1, 0, lat, bc, d, e, st);
        // Called from the done cycle: start is raised while done is high.
        do_op(9, 4, 1, lat, bc, d, e, st);
        n_checks++;
        if (lat !== 4 || d !== 3'd4 || e !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back: got lat=%0d diff=%0d err=%b expected lat=4 diff=4 err=0",
                               lat, d, e);
        end
    endtask

    task automatic test_held_start();
        int sv[3];
        int bv[3];
        int cv[3];
        int ndone = 0;
        int last_k = 0;
        int accepted = 0;
        for (int i = 0; i < 3; i++) begin
            sv[i] = int'($urandom_range(15, 0));
            bv[i] = int'($urandom_range(7, 0));
            cv[i] = int'($urandom_range(1, 0));
        end
        sum_i    = (W+1)'(sv[0]);
        addend_i = W'(bv[0]);
        cin_i    = cv[0][0];
        start    = 1'b1;
        for (int k = 1; k <= 40 && ndone < 3; k++) begin
            @(negedge clk);
            if (done) begin
                n_checks++;
                if (diff_o !== model_diff(sv[ndone], bv[ndone], cv[ndone]) ||
                    err_o !== model_err(sv[ndone], bv[ndone], cv[ndone])) begin
                    n_fail++;
                    $display("FAIL held_start_result%0d: got diff=%0d err=%b expected diff=%0d err=%b",
                             ndone, diff_o, err_o, model_diff(sv[ndone], bv[ndone], cv[ndone]),
                             model_err(sv[ndone], bv[ndone], cv[ndone]));
                end
                if (ndone > 0) begin
                    n_checks++;
                    if (k - last_k !== 5) begin
                        n_fail++;
                        $display("FAIL held_start_interval: got %0d expected 5", k - last_k);
                    end
                end
                last_k = k;
                ndone++;
                if (ndone < 3) begin
                    sum_i    = (W+1)'(sv[ndone]);
                    addend_i = W'(bv[ndone]);
                    cin_i    = cv[ndone][0];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        accepted = ndone;
        n_checks++;
        if (accepted !== 3) begin
            n_fail++; $display("FAIL held_start_count: got %0d expected 3", accepted);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bc;
        int ndone = 0;
        logic [W-1:0] d;
        logic e;
        bit st;
        do_op(2, 5, 0, lat, bc, d, e, st);
        sum_i    = 4'd15;
        addend_i = 3'd0;
        cin_i    = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, diff_o, err_o} !== '0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b done=%b diff=%0d err=%b expected all 0",
                               busy, done, diff_o, err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++; $display("FAIL aborted_op_activity: got %0d active cycles expected 0", ndone);
        end
        do_op(7, 2, 1, lat, bc, d, e, st);
        n_checks++;
        if (lat !== 4 || d !== 3'd4 || e !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_op: got lat=%0d diff=%0d err=%b expected lat=4 diff=4 err=0",
                               lat, d, e);
        end
    endtask

    task automatic test_sweep();
        int lat, bc;
        logic [W-1:0] d;
        logic e;
        bit st;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op(a + b + c, b, c, lat, bc, d, e, st);
                    n_checks++;
                    if (lat !== 4 || d !== W'(a) || e !== 1'b0) begin
                        n_fail++;
                        $display("FAIL sweep a=%0d b=%0d c=%0d: got lat=%0d diff=%0d err=%b expected lat=4 diff=%0d err=0",
                                 a, b, c, lat, d, e, a);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, s, b, c;
        logic [W-1:0] d;
        logic e;
        bit st;
        for (int i = 0; i < 150; i++) begin
            s = int'($urandom_range(15, 0));
            b = int'($urandom_range(7, 0));
            c = int'($urandom_range(1, 0));
            do_op(s, b, c, lat, bc, d, e, st);
            n_checks++;
            if (lat !== 4 || !st || d !== model_diff(s, b, c) || e !== model_err(s, b, c)) begin
                n_fail++;
                $display("FAIL random s=%0d b=%0d c=%0d: got lat=%0d stable=%0d diff=%0d err=%b expected lat=4 stable=1 diff=%0d err=%b",
                         s, b, c, lat, st, d, e, model_diff(s, b, c), model_err(s, b, c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_ignore_start();
        test_back_to_back();
        test_held_start();
        test_async_reset();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
